// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshake on both sides.
// Non-MUL ops complete in one cycle. MUL is an unsigned shift-add
// multiplier that retires one multiplier bit per cycle.
// Optional feature macro: SEQ_ALU_MUL_EN (builds the MUL datapath and BUSY
// state). Without it, opcode 111 completes at once and flags illegal_o.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] alu_o,
   output logic [WIDTH-1:0] hi_o,
   output logic             zero_o,
   output logic             carry_o,
   output logic             ovf_o,
   output logic             illegal_o
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

`ifdef SEQ_ALU_MUL_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

   state_t state;

   // single-cycle result path, evaluated straight from the inputs so the
   // result can be registered on the accepting edge
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   dif;
   logic [WIDTH:0]   shl;
   logic [WIDTH:0]   shr;
   logic [WIDTH-1:0] res;
   logic             cy;
   logic             ov;
   logic             ill;
   logic             is_mul;

   // combinational evaluation of every single-cycle opcode
   always_comb begin
      shamt = b_i[SHW-1:0];
      sum   = {1'b0, a_i} + {1'b0, b_i};
      // top bit of the difference is the borrow (a < b unsigned)
      dif   = {1'b0, a_i} - {1'b0, b_i};
      // the extra bit catches the last bit pushed out; zero for amount 0
      shl   = {1'b0, a_i} << shamt;
      shr   = {a_i, 1'b0} >> shamt;
      res   = '0;
      cy    = 1'b0;
      ov    = 1'b0;
      ill   = 1'b0;
      case (op_i)
         OP_ADD: begin
            res = sum[WIDTH-1:0];
            cy  = sum[WIDTH];
            ov  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SUB: begin
            res = dif[WIDTH-1:0];
            cy  = dif[WIDTH];
            ov  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (dif[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_AND: res = a_i & b_i;
         OP_OR:  res = a_i | b_i;
         OP_XOR: res = a_i ^ b_i;
         OP_SHL: begin
            res = shl[WIDTH-1:0];
            cy  = shl[WIDTH];
         end
         OP_SHR: begin
            res = shr[WIDTH:1];
            cy  = shr[0];
         end
         default: begin
`ifdef SEQ_ALU_MUL_EN
            ill = 1'b0;
`else
            ill = 1'b1;
`endif
         end
      endcase
   end

`ifdef SEQ_ALU_MUL_EN
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   // multiplier lives in acc_lo and is consumed LSB first while the
   // product grows in from the top; after WIDTH steps {acc_hi,acc_lo}
   // holds the full product
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [SHW-1:0]   cnt;
   logic [WIDTH:0]   step_sum;
   logic [WIDTH-1:0] nhi;
   logic [WIDTH-1:0] nlo;

   assign is_mul = (op_i == OP_MUL);

   // one shift-add step
   always_comb begin
      step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
      nhi      = step_sum[WIDTH:1];
      nlo      = {step_sum[0], acc_lo[WIDTH-1:1]};
   end
`else
   assign is_mul = 1'b0;
`endif

   // control FSM with registered handshake, result and flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         in_ready_o  <= 1'b1;
         out_valid_o <= 1'b0;
         alu_o       <= '0;
         hi_o        <= '0;
         zero_o      <= 1'b0;
         carry_o     <= 1'b0;
         ovf_o       <= 1'b0;
         illegal_o   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
         mcand       <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         cnt         <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid_i) begin
                  in_ready_o <= 1'b0;
                  if (is_mul) begin
`ifdef SEQ_ALU_MUL_EN
                     state  <= BUSY;
                     mcand  <= a_i;
                     acc_hi <= '0;
                     acc_lo <= b_i;
                     cnt    <= '0;
`endif
                  end else begin
                     state       <= DONE;
                     out_valid_o <= 1'b1;
                     alu_o       <= res;
                     hi_o        <= '0;
                     zero_o      <= (res == '0);
                     carry_o     <= cy;
                     ovf_o       <= ov;
                     illegal_o   <= ill;
                  end
               end
            end
`ifdef SEQ_ALU_MUL_EN
            BUSY: begin
               acc_hi <= nhi;
               acc_lo <= nlo;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state       <= DONE;
                  out_valid_o <= 1'b1;
                  alu_o       <= nlo;
                  hi_o        <= nhi;
                  zero_o      <= ({nhi, nlo} == '0);
                  carry_o     <= (nhi != '0);
                  ovf_o       <= 1'b0;
                  illegal_o   <= 1'b0;
               end
            end
`endif
            DONE: begin
               if (out_ready_i) begin
                  state       <= IDLE;
                  out_valid_o <= 1'b0;
                  in_ready_o  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_o <= 1'b0;
               in_ready_o  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed plus random stimulus for seq_alu (WIDTH=8) checked
// against an arithmetic reference model. Honors SEQ_ALU_MUL_EN.
module tb_seq_alu;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic [2:0] op_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] alu;
   logic [7:0] hi;
   logic       zero;
   logic       carry;
   logic       ovf;
   logic       illegal;

   int total = 0;
   int bad   = 0;

`ifdef SEQ_ALU_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] alu;
      logic [7:0] hi;
      logic       z;
      logic       c;
      logic       o;
      logic       il;
   } exp_t;

   seq_alu #(.WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a_in),
      .b_i         (b_in),
      .op_i        (op_in),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .alu_o       (alu),
      .hi_o        (hi),
      .zero_o      (zero),
      .carry_o     (carry),
      .ovf_o       (ovf),
      .illegal_o   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference: plain integer arithmetic on unsigned/signed interpretations
   function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned op);
      exp_t e;
      int sa, sb, sr;
      int unsigned s;
      longint unsigned p;
      e  = '0;
      sa = (a >= 128) ? int'(a) - 256 : int'(a);
      sb = (b >= 128) ? int'(b) - 256 : int'(b);
      s  = b % 8;
      case (op)
         0: begin
            p = a + b;
            e.alu = 8'(p % 256);
            e.c = (p > 255);
            sr = sa + sb;
            e.o = (sr > 127) || (sr < -128);
         end
         1: begin
            e.alu = 8'((a + 256 - b) % 256);
            e.c = (a < b);
            sr = sa - sb;
            e.o = (sr > 127) || (sr < -128);
         end
         2: e.alu = 8'(a & b);
         3: e.alu = 8'(a | b);
         4: e.alu = 8'(a ^ b);
         5: begin
            e.alu = 8'((a << s) % 256);
            e.c = (s != 0) && (((a >> (8 - s)) & 1) == 1);
         end
         6: begin
            e.alu = 8'(a >> s);
            e.c = (s != 0) && (((a >> (s - 1)) & 1) == 1);
         end
         default: begin
            if (MUL_ON) begin
               p = longint'(a) * longint'(b);
               e.alu = 8'(p % 256);
               e.hi = 8'(p / 256);
               e.c = (e.hi != 0);
            end else begin
               e.il = 1'b1;
            end
         end
      endcase
      e.z = (e.alu == 0) && (e.hi == 0);
      return e;
   endfunction

   // issue one op, check latency/result, optionally stall the consumer
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int stall);
      exp_t e;
      int lat;
      int exp_lat;
      e = model(a, b, op);
      exp_lat = (op == 3'd7 && MUL_ON) ? 9 : 1;
      @(negedge clk);
      in_valid = 1'b1; a_in = a; b_in = b; op_in = op;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("alu", alu, e.alu);
      chk("hi", hi, e.hi);
      chk("zero", zero, e.z);
      chk("carry", carry, e.c);
      chk("ovf", ovf, e.o);
      chk("illegal", illegal, e.il);
      chk("busy_rdy", in_ready, 0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(0, 1));
         a_in = 8'($urandom); b_in = 8'($urandom); op_in = 3'($urandom);
         @(posedge clk); #1;
         chk("hold_alu", {hi, alu, zero, carry, ovf, illegal}, {e.hi, e.alu, e.z, e.c, e.o, e.il});
         chk("hold_vld", out_valid, 1);
         chk("hold_rdy", in_ready, 0);
      end
      // consume with new operands present: they must not be taken
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1; a_in = 8'($urandom); b_in = 8'($urandom); op_in = 3'($urandom);
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk("consumed", out_valid, 0);
      chk("rdy_back", in_ready, 1);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a_in = '0; b_in = '0; op_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdy", in_ready, 1);
      chk("rst_vld", out_valid, 0);
      chk("rst_out", {hi, alu, zero, carry, ovf, illegal}, 0);
      @(negedge clk);
      reset = 1'b0;

      // directed corner cases
      do_op(8'h7F, 8'h01, 3'd0, 0);
      do_op(8'h03, 8'h07, 3'd1, 0);
      do_op(8'h80, 8'h01, 3'd1, 0);
      do_op(8'h81, 8'h01, 3'd5, 0);
      do_op(8'h07, 8'h03, 3'd6, 0);
      do_op(8'hA5, 8'h08, 3'd5, 0);
      do_op(8'h07, 8'h03, 3'd7, 0);
      do_op(8'hFF, 8'hFF, 3'd7, 5);
      do_op(8'h00, 8'h9C, 3'd7, 0);
      do_op(8'hFF, 8'h01, 3'd0, 5);

      // spot checks of the model itself against hand values
      chk("ref_add", model(8'h7F, 8'h01, 0), {8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
      chk("ref_shr", model(8'h07, 8'h03, 6), {8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});

      // reset 4 cycles into a MUL
      @(negedge clk);
      in_valid = 1'b1; a_in = 8'h55; b_in = 8'h33; op_in = 3'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mrst_rdy", in_ready, 1);
      chk("mrst_vld", out_valid, 0);
      chk("mrst_out", {hi, alu, zero, carry, ovf, illegal}, 0);
      @(negedge clk);
      reset = 1'b0;
      do_op(8'h12, 8'h34, 3'd7, 0);

      // random traffic
      for (int n = 0; n < 60; n++)
         do_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
